ngc_timer_ctrl: RTL

- Master-side controller for the ngc_counter interface. It drives the counter's rst/load/enb/dir/one_shot/from/to/load/step controls and consumes count and count_hit.
- Turns the free counter into a periodic/N-shot timer: programs the terminal values, sequences arm/run/stop, counts completed periods, and emits tick/done pulses.
- Sits between a CSR/command block and one ngc_counter instance.

---
 rtl/ngc_timer_pkg.sv | 8 +
 rtl/ngc_timer_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/ngc_timer_pkg.sv
// ngc_timer_pkg: shared types and constants for the ngc_counter timer controller.
package ngc_timer_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_REP_W = 8;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
endpackage

// File: rtl/ngc_timer_ctrl.sv
// ngc_timer_ctrl: sequences an ngc_counter as a periodic / N-shot timer
// and reports completed periods as tick/done pulses.
module ngc_timer_ctrl
    import ngc_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             reload,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [REP_W-1:0] cfg_repeat,
    input  logic             cfg_dir,
    output logic             cnt_rst,
    output logic             cnt_load,
    output logic             cnt_enb,
    output logic             cnt_dir,
    output logic             cnt_one_shot,
    output logic [WIDTH-1:0] cnt_from,
    output logic [WIDTH-1:0] cnt_to,
    output logic [WIDTH-1:0] cnt_load_value,
    output logic [WIDTH-1:0] cnt_step,
    input  logic             cnt_hit,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] remaining
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_top;
    logic [REP_W-1:0] r_rem;
    logic             r_dir, r_tick, r_done, r_err;
    logic             w_idle, w_run, w_last, w_start_ok, w_comp, w_unused;

    assign w_idle     = r_state == IDLE;
    assign w_run      = r_state == RUN;
    assign w_last     = r_rem == REP_W'(1);
    assign w_start_ok = w_idle && start && (cfg_period != '0);
    // stop and reload both discard a coincident hit; pause freezes the counter
    assign w_comp     = w_run && !stop && !reload && !pause && cnt_hit;
    assign w_unused   = ^cnt_count;

    always_comb begin
        w_next = r_state;
        if (w_idle) w_next = w_start_ok ? ARM : IDLE;
        else if (stop || (w_comp && w_last)) w_next = IDLE;
        else if (r_state == ARM) w_next = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_top   <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tick  <= w_comp;
            r_done  <= w_comp && w_last;
            r_err   <= w_idle && start && (cfg_period == '0);
            if (w_start_ok) begin
                r_top <= cfg_period - 1'b1;
                r_rem <= cfg_repeat;
                r_dir <= cfg_dir;
            end else if (w_comp && (r_rem != '0)) begin
                r_rem <= r_rem - 1'b1;
            end
        end
    end

    assign cnt_rst        = !w_run;
    assign cnt_load       = w_run && reload;
    assign cnt_enb        = w_run && !pause;
    assign cnt_dir        = r_dir;
    assign cnt_one_shot   = w_run && w_last;
    assign cnt_from       = (r_dir == DIR_DOWN) ? r_top : '0;
    assign cnt_to         = (r_dir == DIR_UP) ? r_top : '0;
    assign cnt_load_value = cnt_from;
    assign cnt_step       = WIDTH'(1);
    assign busy           = !w_idle;
    assign tick           = r_tick;
    assign done           = r_done;
    assign err            = r_err;
    assign remaining      = w_idle ? '0 : r_rem;
endmodule
